// File: rtl/nx_rbus_pkg.sv
// nx_rbus_pkg: shared state encoding and default widths for the rbus ring master
package nx_rbus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int ADDR_BITS_DEF = 16;
  localparam int DATA_BITS_DEF = 32;
  localparam int TIMEOUT_DEF = 1023;
endpackage

// File: rtl/nx_rr_arb.sv
// nx_rr_arb: combinational N-way round-robin arbiter, search starts at last+1
//   req  - request vector
//   last - index of the previous winner
//   gnt  - one-hot grant (all zero when no request)
//   idx  - index of the granted requester
module nx_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  // Walk offsets from farthest to nearest so the closest requester after last wins.
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) idx = ($clog2(N))'((int'(last) + i) % N);
  end
  assign gnt = (|req) ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/nx_rbus_master_arb.sv
// nx_rbus_master_arb: round-robin sequencer sharing one rbus ring master port
//   req_*   - per-requester valid/wr/addr/wdata, one-hot ready accept pulse
//   rsp_*   - one-hot completion pulse with rdata, err and timeout flags
//   rbus_*  - ring address/data/strobes out, read data and acks back
//   busy_o  - transaction in flight; stray_ack_o - sticky unexpected ack
module nx_rbus_master_arb import nx_rbus_pkg::*; #(
  parameter int N_REQ            = N_REQ_DEF,
  parameter int N_RBUS_ADDR_BITS = ADDR_BITS_DEF,
  parameter int N_RBUS_DATA_BITS = DATA_BITS_DEF,
  parameter int TIMEOUT_CYCLES   = TIMEOUT_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid_i,
  input  logic [N_REQ-1:0]                    req_wr_i,
  input  logic [N_REQ*N_RBUS_ADDR_BITS-1:0]   req_addr_i,
  input  logic [N_REQ*N_RBUS_DATA_BITS-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  output logic [N_REQ-1:0]                    rsp_valid_o,
  output logic [N_RBUS_DATA_BITS-1:0]         rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                rsp_timeout_o,
  output logic [N_RBUS_ADDR_BITS-1:0]         rbus_addr_o,
  output logic                                rbus_wr_strb_o,
  output logic [N_RBUS_DATA_BITS-1:0]         rbus_wr_data_o,
  output logic                                rbus_rd_strb_o,
  input  logic [N_RBUS_DATA_BITS-1:0]         rbus_rd_data_i,
  input  logic                                rbus_ack_i,
  input  logic                                rbus_err_ack_i,
  output logic                                busy_o,
  output logic                                stray_ack_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = N_RBUS_ADDR_BITS;
  localparam int DW = N_RBUS_DATA_BITS;
  state_t          state;
  logic [IW-1:0]   last_grant, owner, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic            lat_wr, lat_err, lat_to;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata, lat_rdata;
  logic [CW-1:0]   cnt;
  logic            ack_any;
  assign ack_any = rbus_ack_i | rbus_err_ack_i;
  nx_rr_arb #(.N(N_REQ)) u_arb (
    .req  (req_valid_i),
    .last (last_grant),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IW'(N_REQ - 1);
      owner          <= '0;
      lat_wr         <= 1'b0;
      lat_err        <= 1'b0;
      lat_to         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_rdata      <= '0;
      cnt            <= '0;
      req_ready_o    <= '0;
      rsp_valid_o    <= '0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      rsp_timeout_o  <= 1'b0;
      rbus_addr_o    <= '0;
      rbus_wr_strb_o <= 1'b0;
      rbus_wr_data_o <= '0;
      rbus_rd_strb_o <= 1'b0;
      busy_o         <= 1'b0;
      stray_ack_o    <= 1'b0;
    end else begin
      req_ready_o    <= '0;
      rsp_valid_o    <= '0;
      rbus_wr_strb_o <= 1'b0;
      rbus_rd_strb_o <= 1'b0;
      if (ack_any && state != WAIT) stray_ack_o <= 1'b1;
      case (state)
        IDLE: if (|req_valid_i) begin
          owner       <= gnt_idx;
          lat_wr      <= req_wr_i[gnt_idx];
          lat_addr    <= req_addr_i[gnt_idx*AW +: AW];
          lat_wdata   <= req_wdata_i[gnt_idx*DW +: DW];
          req_ready_o <= gnt;
          busy_o      <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          rbus_addr_o    <= lat_addr;
          rbus_wr_data_o <= lat_wr ? lat_wdata : '0;
          rbus_wr_strb_o <= lat_wr;
          rbus_rd_strb_o <= !lat_wr;
          cnt            <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          cnt <= (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
          // An ack on the terminal cycle wins over the timeout.
          if (ack_any) begin
            lat_rdata <= (rbus_ack_i && !rbus_err_ack_i && !lat_wr) ? rbus_rd_data_i : '0;
            lat_err   <= rbus_err_ack_i;
            lat_to    <= 1'b0;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            lat_rdata <= '0;
            lat_err   <= 1'b1;
            lat_to    <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_o   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
          rsp_rdata_o   <= lat_rdata;
          rsp_err_o     <= lat_err;
          rsp_timeout_o <= lat_to;
          last_grant    <= owner;
          busy_o        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nx_rbus_master_arb.sv
// tb_nx_rbus_master_arb: randomized self-checking bench against a transaction-level model
module tb_nx_rbus_master_arb;
  localparam int N = 4, AW = 16, DW = 32, TO = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_valid_i = '0, req_wr_i = '0, req_ready_o, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [DW-1:0] rsp_rdata_o, rbus_wr_data_o, rbus_rd_data_i = '0;
  logic [AW-1:0] rbus_addr_o;
  logic rsp_err_o, rsp_timeout_o, rbus_wr_strb_o, rbus_rd_strb_o, busy_o, stray_ack_o;
  logic rbus_ack_i = 1'b0, rbus_err_ack_i = 1'b0;
  int n_cmp = 0, n_bad = 0, last = N - 1;
  logic stray_exp = 1'b0;
  logic [AW-1:0] a_m[N];
  logic [DW-1:0] d_m[N];
  logic w_m[N];
  nx_rbus_master_arb #(.N_REQ(N), .N_RBUS_ADDR_BITS(AW), .N_RBUS_DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .rbus_addr_o(rbus_addr_o), .rbus_wr_strb_o(rbus_wr_strb_o),
    .rbus_wr_data_o(rbus_wr_data_o), .rbus_rd_strb_o(rbus_rd_strb_o), .rbus_rd_data_i(rbus_rd_data_i),
    .rbus_ack_i(rbus_ack_i), .rbus_err_ack_i(rbus_err_ack_i), .busy_o(busy_o), .stray_ack_o(stray_ack_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int rr_pick(input int l, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) if (v[(l + i) % N]) return (l + i) % N;
    return -1;
  endfunction
  task automatic drive_req(input logic [N-1:0] v);
    req_valid_i = v;
    for (int i = 0; i < N; i++) begin
      req_wr_i[i] = w_m[i];
      req_addr_i[i*AW +: AW] = a_m[i];
      req_wdata_i[i*DW +: DW] = d_m[i];
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_rsp"}, rsp_valid_o, 0);
    chk({tag, "_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_err"}, rsp_err_o, 0);
    chk({tag, "_to"}, rsp_timeout_o, 0);
    chk({tag, "_addr"}, rbus_addr_o, 0);
    chk({tag, "_wstrb"}, rbus_wr_strb_o, 0);
    chk({tag, "_wdata"}, rbus_wr_data_o, 0);
    chk({tag, "_rstrb"}, rbus_rd_strb_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_stray"}, stray_ack_o, 0);
  endtask
  // kind: 0 ack, 1 err_ack, 2 both; wait index d >= TO means the ring stays silent
  task automatic txn(input logic [N-1:0] v, input int d, input int kind, input logic [DW-1:0] rd);
    int win;
    logic [DW-1:0] exp_rd;
    logic exp_err, exp_to, done;
    win = rr_pick(last, v);
    exp_to = d >= TO;
    exp_err = exp_to || kind != 0;
    exp_rd = (exp_err || w_m[win]) ? '0 : rd;
    drive_req(v);
    tick;
    chk("ready", req_ready_o, 64'(1) << win);
    chk("busy", busy_o, 1);
    req_valid_i = '0;
    tick;
    chk("ready_pulse", req_ready_o, 0);
    chk("wr_strb", rbus_wr_strb_o, w_m[win]);
    chk("rd_strb", rbus_rd_strb_o, !w_m[win]);
    chk("addr", rbus_addr_o, a_m[win]);
    chk("wr_data", rbus_wr_data_o, w_m[win] ? d_m[win] : '0);
    done = 1'b0;
    for (int w = 0; w < TO && !done; w++) begin
      if (w == d) begin
        rbus_ack_i = kind != 1;
        rbus_err_ack_i = kind != 0;
        rbus_rd_data_i = rd;
        done = 1'b1;
      end else rbus_rd_data_i = $urandom;
      tick;
      rbus_ack_i = 1'b0;
      rbus_err_ack_i = 1'b0;
      chk("no_rsp_wait", rsp_valid_o, 0);
      chk("strb_off", {rbus_wr_strb_o, rbus_rd_strb_o}, 0);
    end
    tick;
    chk("rsp_valid", rsp_valid_o, 64'(1) << win);
    chk("rsp_rdata", rsp_rdata_o, exp_rd);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("rsp_timeout", rsp_timeout_o, exp_to);
    chk("busy_end", busy_o, 0);
    chk("stray", stray_ack_o, stray_exp);
    last = win;
  endtask
  task automatic stray_pulse;
    rbus_ack_i = $urandom_range(0, 1) == 1;
    rbus_err_ack_i = !rbus_ack_i;
    tick;
    rbus_ack_i = 1'b0;
    rbus_err_ack_i = 1'b0;
    tick;
    stray_exp = 1'b1;
    chk("stray_set", stray_ack_o, 1);
    chk("stray_no_rsp", rsp_valid_o, 0);
  endtask
  task automatic randomize_reqs;
    for (int i = 0; i < N; i++) begin
      a_m[i] = AW'($urandom);
      d_m[i] = $urandom;
      w_m[i] = $urandom_range(0, 1) == 1;
    end
  endtask
  initial begin
    randomize_reqs();
    #2 rst_n = 1'b0;
    repeat (2) tick;
    check_idle_outputs("reset");
    #3 rst_n = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      randomize_reqs();
      txn(4'b1111, 0, 0, $urandom);
    end
    chk("rr_wrap_last", last, 0);
    a_m[2] = 16'h8004; d_m[2] = 32'hA5A5A5A5; w_m[2] = 1'b1;
    txn(4'b0100, 1, 1, 32'h12345678);
    a_m[0] = 16'h0123; w_m[0] = 1'b0;
    txn(4'b0001, 3, 0, 32'hDEADBEEF);
    txn(4'b0001, TO, 0, 32'h0);
    txn(4'b0001, TO - 1, 0, 32'hCAFEF00D);
    txn(4'b0010, TO - 1, 2, 32'hCAFEF00D);
    stray_pulse();
    chk("stray_sticky", stray_ack_o, 1);
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] v;
      randomize_reqs();
      v = N'($urandom_range(1, (1 << N) - 1));
      txn(v, $urandom_range(0, TO + 1), $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 5) == 0) stray_pulse();
    end
    randomize_reqs();
    drive_req(4'b1110);
    tick;
    req_valid_i = '0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    last = N - 1;
    stray_exp = 1'b0;
    tick;
    #2 rst_n = 1'b1;
    tick;
    stray_pulse();
    randomize_reqs();
    txn(4'b1111, 2, 0, $urandom);
    chk("post_reset_winner", last, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
